// File: rtl/uart_frame_sequencer.sv
// Buffers 16-bit samples in a small FIFO and sends each one to a byte-level UART
// transmitter as a frame: SYNC_BYTE, MSB, LSB and an optional XOR checksum.
module uart_frame_sequencer #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter bit          CHECKSUM_EN = 1'b1,
  parameter int unsigned ACT_TIMEOUT = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_sample,
  input  logic        i_sample_valid,
  output logic        o_sample_ready,
  output logic        o_txsend,
  output logic [7:0]  o_txbyte,
  input  logic        i_txactive,
  output logic        o_busy,
  output logic        o_overflow,
  output logic        o_err,
  output logic [15:0] o_frame_cnt
);

  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned TO_W     = $clog2(ACT_TIMEOUT + 1);
  localparam logic [1:0]  LAST_IDX = CHECKSUM_EN ? 2'd3 : 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT_ACT,
    S_WAIT_DONE,
    S_GAP
  } state_e;

  // Sample FIFO
  logic [15:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             full;
  logic             push;
  logic             pop;
  logic             overflow_q;
  logic [15:0]      head;

  // Frame sequencer
  state_e           state_q;
  logic [1:0]       idx_q;
  logic [15:0]      frame_q;
  logic             txsend_q;
  logic [7:0]       txbyte_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic             err_q;
  logic [15:0]      frame_cnt_q;

  function automatic logic [7:0] frame_byte(input logic [15:0] s, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = SYNC_BYTE;
      2'd1:    b = s[15:8];
      2'd2:    b = s[7:0];
      default: b = s[15:8] ^ s[7:0];
    endcase
    return b;
  endfunction

  assign full = (count_q == CNT_W'(FIFO_DEPTH));
  assign push = i_sample_valid & ~full;
  assign pop  = (state_q == S_LOAD);
  assign head = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: default assignment first, so no path through this block can infer a latch.
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      if (i_sample_valid && full) overflow_q <= 1'b1;
    end
  end

  // NOTE: sample storage has no reset; count_q alone decides which entries are valid.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_sample;
  end

  // o_txsend is high only in SEND; o_txbyte changes only on entry to SEND.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      idx_q       <= 2'd0;
      frame_q     <= '0;
      txsend_q    <= 1'b0;
      txbyte_q    <= '0;
      to_cnt_q    <= '0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      txsend_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if ((count_q != '0) && !i_txactive) state_q <= S_LOAD;
        end
        S_LOAD: begin
          frame_q  <= head;
          idx_q    <= 2'd0;
          txsend_q <= 1'b1;
          txbyte_q <= frame_byte(head, 2'd0);
          state_q  <= S_SEND;
        end
        S_SEND: begin
          to_cnt_q <= '0;
          state_q  <= S_WAIT_ACT;
        end
        S_WAIT_ACT: begin
          if (i_txactive) begin
            state_q <= S_WAIT_DONE;
          end else if (to_cnt_q == TO_W'(ACT_TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!i_txactive) state_q <= S_GAP;
        end
        S_GAP: begin
          if (idx_q != LAST_IDX) begin
            idx_q    <= idx_q + 2'd1;
            txsend_q <= 1'b1;
            txbyte_q <= frame_byte(frame_q, idx_q + 2'd1);
            state_q  <= S_SEND;
          end else begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_sample_ready = ~full;
  assign o_txsend       = txsend_q;
  assign o_txbyte       = txbyte_q;
  assign o_busy         = (state_q != S_IDLE) | (count_q != '0);
  assign o_overflow     = overflow_q;
  assign o_err          = err_q;
  assign o_frame_cnt    = frame_cnt_q;

endmodule
